// File: rtl/hpm_window_checker.sv
// Serial HPM window checker: snapshots the counter bank on each EnableDetect rising edge,
// checks one saturated per-counter delta per cycle against [lo, hi], and hands EndDetect back.
module hpm_window_checker #(
    parameter int NUM_CNT = 12,
    parameter int DELTA_W = 32,
    parameter int STAT_W  = 16
) (
    input  logic                      clk_h,
    input  logic                      rst_h,
    input  logic [31:0][63:0]         HPMout,
    input  logic                      EnableDetect,
    output logic                      EndDetect,
    input  logic                      cfg_we,
    input  logic [3:0]                cfg_idx,
    input  logic [DELTA_W-1:0]        cfg_lo,
    input  logic [DELTA_W-1:0]        cfg_hi,
    output logic                      cfg_busy,
    output logic                      alarm,
    output logic [NUM_CNT-1:0]        alarm_vec,
    output logic                      baseline_valid,
    output logic [STAT_W-1:0]         window_cnt,
    output logic [STAT_W-1:0]         alarm_cnt
);
    localparam logic [4:0] CNT_L    = 5'(NUM_CNT);
    localparam logic [3:0] IDX_LAST = 4'(NUM_CNT - 1);

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_CHECK, S_REPORT, S_HOLD} state_t;

    state_t                           state_q, state_d;
    logic                             en_q, en_d;
    logic [3:0]                       idx_q, idx_d;
    logic [NUM_CNT-1:0][63:0]         cur_q, cur_d, prev_q, prev_d;
    logic [NUM_CNT-1:0][DELTA_W-1:0]  lo_q, lo_d, hi_q, hi_d;
    logic [NUM_CNT-1:0]               scratch_q, scratch_d, alarm_vec_q, alarm_vec_d;
    logic                             end_detect_q, end_detect_d, cfg_busy_q, cfg_busy_d;
    logic                             alarm_q, alarm_d, baseline_valid_q, baseline_valid_d;
    logic [STAT_W-1:0]                window_cnt_q, window_cnt_d, alarm_cnt_q, alarm_cnt_d;
    logic [63:0]                      delta;
    logic [DELTA_W-1:0]               delta_sat;
    logic                             unused_hpm;

    assign unused_hpm = ^HPMout;

    // Modulo-2^64 difference keeps source-counter wrap-around a small positive delta.
    assign delta     = cur_q[idx_q] - prev_q[idx_q];
    assign delta_sat = (|delta[63:DELTA_W]) ? '1 : delta[DELTA_W-1:0];

    always_comb begin
        state_d          = state_q;
        en_d             = EnableDetect;
        idx_d            = idx_q;
        cur_d            = cur_q;
        prev_d           = prev_q;
        lo_d             = lo_q;
        hi_d             = hi_q;
        scratch_d        = scratch_q;
        alarm_vec_d      = alarm_vec_q;
        alarm_d          = alarm_q;
        baseline_valid_d = baseline_valid_q;
        window_cnt_d     = window_cnt_q;
        alarm_cnt_d      = alarm_cnt_q;

        if (cfg_we && !cfg_busy_q && ({1'b0, cfg_idx} < CNT_L)) begin
            lo_d[cfg_idx] = cfg_lo;
            hi_d[cfg_idx] = cfg_hi;
        end

        case (state_q)
            S_IDLE: begin
                if (EnableDetect && !en_q) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                cur_d     = HPMout[NUM_CNT-1:0];
                idx_d     = '0;
                scratch_d = '0;
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                if (baseline_valid_q && (delta_sat < lo_q[idx_q] || delta_sat > hi_q[idx_q]))
                    scratch_d[idx_q] = 1'b1;
                prev_d[idx_q] = cur_q[idx_q];
                if (idx_q == IDX_LAST) state_d = S_REPORT;
                else                   idx_d   = idx_q + 4'd1;
            end
            S_REPORT: begin
                alarm_vec_d      = scratch_q;
                alarm_d          = |scratch_q;
                window_cnt_d     = window_cnt_q + 1'b1;
                if (|scratch_q && alarm_cnt_q != '1) alarm_cnt_d = alarm_cnt_q + 1'b1;
                baseline_valid_d = 1'b1;
                state_d          = EnableDetect ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!EnableDetect) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        end_detect_d = (state_d == S_HOLD);
        cfg_busy_d   = (state_d == S_CAPTURE) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            state_q          <= S_IDLE;
            en_q             <= 1'b0;
            idx_q            <= '0;
            cur_q            <= '0;
            prev_q           <= '0;
            lo_q             <= '0;
            hi_q             <= '1;
            scratch_q        <= '0;
            alarm_vec_q      <= '0;
            alarm_q          <= 1'b0;
            baseline_valid_q <= 1'b0;
            window_cnt_q     <= '0;
            alarm_cnt_q      <= '0;
            end_detect_q     <= 1'b0;
            cfg_busy_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            en_q             <= en_d;
            idx_q            <= idx_d;
            cur_q            <= cur_d;
            prev_q           <= prev_d;
            lo_q             <= lo_d;
            hi_q             <= hi_d;
            scratch_q        <= scratch_d;
            alarm_vec_q      <= alarm_vec_d;
            alarm_q          <= alarm_d;
            baseline_valid_q <= baseline_valid_d;
            window_cnt_q     <= window_cnt_d;
            alarm_cnt_q      <= alarm_cnt_d;
            end_detect_q     <= end_detect_d;
            cfg_busy_q       <= cfg_busy_d;
        end
    end

    assign EndDetect      = end_detect_q;
    assign cfg_busy       = cfg_busy_q;
    assign alarm          = alarm_q;
    assign alarm_vec      = alarm_vec_q;
    assign baseline_valid = baseline_valid_q;
    assign window_cnt     = window_cnt_q;
    assign alarm_cnt      = alarm_cnt_q;
endmodule

// File: tb/tb_hpm_window_checker.sv
// Directed + randomized bench for hpm_window_checker against a window-level reference model.
module tb_hpm_window_checker;
    localparam int NUM_CNT = 12;
    localparam int DELTA_W = 32;
    localparam int STAT_W  = 16;

    logic                 clk_h = 1'b0;
    logic                 rst_h;
    logic [31:0][63:0]    HPMout;
    logic                 EnableDetect;
    logic                 EndDetect;
    logic                 cfg_we;
    logic [3:0]           cfg_idx;
    logic [DELTA_W-1:0]   cfg_lo, cfg_hi;
    logic                 cfg_busy, alarm, baseline_valid;
    logic [NUM_CNT-1:0]   alarm_vec;
    logic [STAT_W-1:0]    window_cnt, alarm_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state, kept at window granularity.
    logic [63:0]          prev_m [NUM_CNT];
    logic [DELTA_W-1:0]   lo_m   [NUM_CNT];
    logic [DELTA_W-1:0]   hi_m   [NUM_CNT];
    bit                   base_m;
    logic [STAT_W-1:0]    wcnt_m, acnt_m;
    logic [NUM_CNT-1:0]   vec_m;

    hpm_window_checker #(.NUM_CNT(NUM_CNT), .DELTA_W(DELTA_W), .STAT_W(STAT_W)) dut (
        .clk_h(clk_h), .rst_h(rst_h), .HPMout(HPMout), .EnableDetect(EnableDetect),
        .EndDetect(EndDetect), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lo(cfg_lo),
        .cfg_hi(cfg_hi), .cfg_busy(cfg_busy), .alarm(alarm), .alarm_vec(alarm_vec),
        .baseline_valid(baseline_valid), .window_cnt(window_cnt), .alarm_cnt(alarm_cnt)
    );

    always #5 clk_h = ~clk_h;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CNT; k++) begin
            prev_m[k] = '0; lo_m[k] = '0; hi_m[k] = '1;
        end
        base_m = 0; wcnt_m = '0; acnt_m = '0; vec_m = '0;
    endtask

    task automatic model_window();
        logic [63:0] d;
        vec_m = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            d = HPMout[k] - prev_m[k];
            if (d > 64'hFFFF_FFFF) d = 64'hFFFF_FFFF;
            if (base_m && (d < 64'(lo_m[k]) || d > 64'(hi_m[k]))) vec_m[k] = 1'b1;
            prev_m[k] = HPMout[k];
        end
        base_m = 1;
        wcnt_m = wcnt_m + 1'b1;
        if (vec_m != 0 && acnt_m != '1) acnt_m = acnt_m + 1'b1;
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [DELTA_W-1:0] lo, input logic [DELTA_W-1:0] hi);
        @(posedge clk_h); #1;
        cfg_we = 1; cfg_idx = idx; cfg_lo = lo; cfg_hi = hi;
        @(posedge clk_h); #1;
        cfg_we = 0;
        if (idx < NUM_CNT) begin lo_m[idx] = lo; hi_m[idx] = hi; end
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_vec"},   64'(alarm_vec),      64'(vec_m));
        chk({tag, "_alarm"}, 64'(alarm),          64'(vec_m != 0));
        chk({tag, "_wcnt"},  64'(window_cnt),     64'(wcnt_m));
        chk({tag, "_acnt"},  64'(alarm_cnt),      64'(acnt_m));
        chk({tag, "_base"},  64'(baseline_valid), 64'(1));
    endtask

    // One window: drop_at>0 lowers EnableDetect after that cycle; hold_extra keeps it high in HOLD.
    task automatic run_win(input string tag, input int drop_at, input int hold_extra, input bit poke);
        int lat;
        model_window();
        @(posedge clk_h); #1;
        EnableDetect = 1;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_h);
            if (c == drop_at) begin #1; EnableDetect = 0; end
            if (poke && c == 4) begin #1; cfg_we = 1; cfg_idx = 4'd3; cfg_lo = '1; cfg_hi = '1; end
            if (poke && c == 5) begin #1; cfg_we = 0; end
            @(negedge clk_h);
            if (poke && c == 4) chk({tag, "_busy"}, 64'(cfg_busy), 64'(1));
            if (EndDetect && lat == 0) lat = c;
            if (lat != 0) break;
        end
        if (drop_at > 0) chk({tag, "_noend"}, 64'(lat), 64'(0));
        else             chk({tag, "_latency"}, 64'(lat), 64'(15));
        if (hold_extra > 0) begin
            repeat (hold_extra) @(negedge clk_h);
            chk({tag, "_hold_end"},  64'(EndDetect),  64'(1));
            chk({tag, "_hold_wcnt"}, 64'(window_cnt), 64'(wcnt_m));
        end
        EnableDetect = 0;
        @(negedge clk_h);
        @(negedge clk_h);
        chk({tag, "_end_drop"}, 64'(EndDetect), 64'(0));
        check_results(tag);
    endtask

    initial begin
        rst_h = 0; EnableDetect = 0; cfg_we = 0; cfg_idx = '0; cfg_lo = '0; cfg_hi = '0;
        HPMout = '0;
        model_reset();
        #3;
        chk("rst_end",   64'(EndDetect),      64'(0));
        chk("rst_busy",  64'(cfg_busy),       64'(0));
        chk("rst_alarm", 64'(alarm),          64'(0));
        chk("rst_vec",   64'(alarm_vec),      64'(0));
        chk("rst_base",  64'(baseline_valid), 64'(0));
        chk("rst_wcnt",  64'(window_cnt),     64'(0));
        chk("rst_acnt",  64'(alarm_cnt),      64'(0));
        #10 rst_h = 1;

        // Baseline window.
        for (int k = 0; k < 32; k++) HPMout[k] = 64'(100 * k);
        run_win("w1", 0, 0, 0);
        chk("w1_wcnt_one", 64'(window_cnt), 64'(1));

        // Window bound on counter 2, plus an out-of-range write that must vanish.
        cfg_write(4'd2, 32'd10, 32'd20);
        cfg_write(4'd13, 32'd5, 32'd5);
        for (int k = 0; k < NUM_CNT; k++) HPMout[k] += (k == 2) ? 64'd25 : 64'd15;
        run_win("w2", 0, 20, 0);
        chk("w2_vec_const", 64'(alarm_vec), 64'h004);

        // Source-counter wrap on counter 5, then a saturating delta.
        cfg_write(4'd5, 32'h10, 32'h20);
        for (int k = 0; k < NUM_CNT; k++) HPMout[k] += 64'd15;
        HPMout[5] = 64'hFFFF_FFFF_FFFF_FFF0;
        run_win("w3", 0, 0, 0);
        for (int k = 0; k < NUM_CNT; k++) HPMout[k] += 64'd15;
        HPMout[5] = 64'h5;
        run_win("w4_wrap", 0, 0, 0);
        chk("w4_bit5", 64'(alarm_vec[5]), 64'(0));
        for (int k = 0; k < NUM_CNT; k++) HPMout[k] += 64'd15;
        HPMout[5] = HPMout[5] + (64'd1 << 40);
        run_win("w5_sat", 0, 0, 0);
        chk("w5_bit5", 64'(alarm_vec[5]), 64'(1));

        // Config write during CHECK must be dropped.
        for (int k = 0; k < NUM_CNT; k++) HPMout[k] += 64'd15;
        run_win("w6_poke", 0, 0, 1);
        for (int k = 0; k < NUM_CNT; k++) HPMout[k] += 64'd15;
        run_win("w6b_after", 0, 0, 0);

        // EnableDetect dropped mid-CHECK.
        for (int k = 0; k < NUM_CNT; k++) HPMout[k] += 64'd12;
        run_win("w7_drop", 6, 0, 0);

        // Randomized windows and thresholds.
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1)
                cfg_write(4'($urandom_range(0, 15)), 32'($urandom_range(0, 30)), 32'($urandom_range(5, 45)));
            for (int k = 0; k < 32; k++) begin
                if (k >= NUM_CNT) HPMout[k] = {$urandom, $urandom};
                else begin
                    HPMout[k] += 64'($urandom_range(0, 50));
                    if ($urandom_range(0, 7) == 0) HPMout[k] += (64'd1 << $urandom_range(32, 50));
                end
            end
            run_win($sformatf("rnd%0d", i), 0, 0, 0);
        end

        // Reset mid-CHECK.
        @(posedge clk_h); #1;
        EnableDetect = 1;
        repeat (5) @(posedge clk_h);
        #1 rst_h = 0;
        #1;
        chk("mrst_end",  64'(EndDetect),      64'(0));
        chk("mrst_busy", 64'(cfg_busy),       64'(0));
        chk("mrst_vec",  64'(alarm_vec),      64'(0));
        chk("mrst_base", 64'(baseline_valid), 64'(0));
        chk("mrst_wcnt", 64'(window_cnt),     64'(0));
        chk("mrst_acnt", 64'(alarm_cnt),      64'(0));
        model_reset();
        EnableDetect = 0;
        @(posedge clk_h); #1 rst_h = 1;
        for (int k = 0; k < NUM_CNT; k++) HPMout[k] += 64'd7;
        run_win("post_rst", 0, 0, 0);
        chk("post_rst_wcnt", 64'(window_cnt), 64'(1));
        chk("post_rst_alarm", 64'(alarm), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
